// File: rtl/tick_divider_bank_if.sv
// Configuration port of tick_divider_bank: write request fields plus
// per-channel pending/ack status and the one-cycle reject pulse.
interface tick_divider_bank_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned WIDTH = 28
);
    logic             cfg_we_i;
    logic [SELW-1:0]  cfg_sel_i;
    logic [WIDTH-1:0] cfg_div_i;
    logic [WIDTH-1:0] cfg_duty_i;
    logic             cfg_err_o;
    logic [NCH-1:0]   cfg_pend_o;
    logic [NCH-1:0]   cfg_ack_o;

    modport master (
        output cfg_we_i, cfg_sel_i, cfg_div_i, cfg_duty_i,
        input  cfg_err_o, cfg_pend_o, cfg_ack_o
    );

    modport slave (
        input  cfg_we_i, cfg_sel_i, cfg_div_i, cfg_duty_i,
        output cfg_err_o, cfg_pend_o, cfg_ack_o
    );
endinterface

// File: rtl/tick_divider_bank.sv
// Multi-channel run-time programmable tick/level divider. New divisor and
// duty settings are staged and swapped in only at a period boundary.
module tick_divider_bank #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SELW        = 2,
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 100000000
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic [NCH-1:0]      en_i,
    tick_divider_bank_if.slave  cfg,
    output logic [NCH-1:0]      clk_o,
    output logic [NCH-1:0]      tick_o
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_HI  = WIDTH'(DEFAULT_DIV / 2);

    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] hi;
    } ch_cfg_t;

    logic             sel_ok_c;
    logic             wr_ok_c;
    logic [WIDTH-1:0] hi_new_c;
    logic             err_q;
    logic [NCH-1:0]   pend_v;
    logic [NCH-1:0]   ack_v;

    // Write validation and duty default shared by all channels
    always_comb begin
        sel_ok_c = 1'b0;
        wr_ok_c  = 1'b0;
        hi_new_c = cfg.cfg_duty_i;
        sel_ok_c = (32'(cfg.cfg_sel_i) < NCH);
        wr_ok_c  = cfg.cfg_we_i && sel_ok_c
                   && (cfg.cfg_div_i >= WIDTH'(2))
                   && (cfg.cfg_duty_i < cfg.cfg_div_i);
        if (cfg.cfg_duty_i == '0) begin
            hi_new_c = cfg.cfg_div_i >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cfg.cfg_we_i && !wr_ok_c;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ch_cfg_t          act_q;
        ch_cfg_t          stg_q;
        logic [WIDTH-1:0] cnt_q;
        logic             pend_q;
        logic             ack_q;
        logic             clk_q;
        logic             tick_q;
        logic             wrap_c;
        logic             apply_c;
        logic             hit_c;

        // Apply happens at the period boundary, or at once while idle
        always_comb begin
            wrap_c  = 1'b0;
            apply_c = 1'b0;
            hit_c   = 1'b0;
            wrap_c  = (cnt_q == act_q.div - WIDTH'(1));
            apply_c = pend_q && (!en_i[g] || wrap_c);
            hit_c   = wr_ok_c && (cfg.cfg_sel_i == SELW'(g));
        end

        always_ff @(posedge clk_i or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                act_q  <= '{div: DEF_DIV, hi: DEF_HI};
                stg_q  <= '{div: DEF_DIV, hi: DEF_HI};
                pend_q <= 1'b0;
                ack_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (en_i[g]) begin
                    cnt_q  <= wrap_c ? '0 : cnt_q + WIDTH'(1);
                    clk_q  <= (cnt_q < act_q.hi);
                    tick_q <= wrap_c;
                end else begin
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end

                if (apply_c) begin
                    act_q <= stg_q;
                end
                ack_q <= apply_c;

                // A same-edge write re-stages after the old value is applied
                if (hit_c) begin
                    stg_q  <= '{div: cfg.cfg_div_i, hi: hi_new_c};
                    pend_q <= 1'b1;
                end else if (apply_c) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign clk_o[g]  = clk_q;
        assign tick_o[g] = tick_q;
        assign pend_v[g] = pend_q;
        assign ack_v[g]  = ack_q;
    end

    assign cfg.cfg_err_o  = err_q;
    assign cfg.cfg_pend_o = pend_v;
    assign cfg.cfg_ack_o  = ack_v;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank: three channels, DEFAULT_DIV=10.
module tb_tick_divider_bank;

    localparam int unsigned NCH   = 3;
    localparam int unsigned SELW  = 2;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DDIV  = 10;

    logic             clk_i;
    logic             reset;
    logic [NCH-1:0]   en_i;
    logic [NCH-1:0]   clk_o;
    logic [NCH-1:0]   tick_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int en12_cyc    = 0;

    tick_divider_bank_if #(.NCH(NCH), .SELW(SELW), .WIDTH(WIDTH)) cfg_if ();

    tick_divider_bank #(
        .NCH(NCH), .SELW(SELW), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)
    ) dut (
        .clk_i  (clk_i),
        .reset  (reset),
        .en_i   (en_i),
        .cfg    (cfg_if),
        .clk_o  (clk_o),
        .tick_o (tick_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] div, input logic [15:0] duty);
        cfg_if.cfg_we_i   = 1'b1;
        cfg_if.cfg_sel_i  = sel;
        cfg_if.cfg_div_i  = div;
        cfg_if.cfg_duty_i = duty;
    endtask

    // {clk2, clk1, tick2, tick1} for ch1 div=5 hi=1 and ch2 div=2 hi=1
    function automatic logic [3:0] exp12(input int i);
        return {(i % 2) == 0, (i % 5) == 0, (i % 2) == 1, (i % 5) == 4};
    endfunction

    task automatic test_reset();
        logic [11:0] got;
        reset = 1'b1;
        en_i  = '0;
        cfg_if.cfg_we_i   = 1'b0;
        cfg_if.cfg_sel_i  = '0;
        cfg_if.cfg_div_i  = '0;
        cfg_if.cfg_duty_i = '0;
        #1 reset = 1'b0;
        #2;
        got = {clk_o, tick_o, cfg_if.cfg_pend_o, cfg_if.cfg_ack_o};
        vectors++;
        if (got !== 12'h0 || cfg_if.cfg_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %h err %b want 000 err 0", got, cfg_if.cfg_err_o);
        end
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            got = {clk_o, tick_o, cfg_if.cfg_pend_o, cfg_if.cfg_ack_o};
            vectors++;
            if (got !== 12'h0 || cfg_if.cfg_err_o !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_%0d: got %h err %b want 000 err 0", i, got, cfg_if.cfg_err_o);
            end
        end
    endtask

    task automatic test_ch0_basic();
        wr(2'd0, 16'd4, 16'd0);
        step();
        cfg_if.cfg_we_i = 1'b0;
        vectors++;
        if (cfg_if.cfg_pend_o !== 3'b001 || cfg_if.cfg_ack_o !== 3'b000) begin
            miscompares++;
            $display("FAIL ch0_pend: got pend %b ack %b want 001 000", cfg_if.cfg_pend_o, cfg_if.cfg_ack_o);
        end
        step();
        vectors++;
        if (cfg_if.cfg_pend_o !== 3'b000 || cfg_if.cfg_ack_o !== 3'b001) begin
            miscompares++;
            $display("FAIL ch0_ack: got pend %b ack %b want 000 001", cfg_if.cfg_pend_o, cfg_if.cfg_ack_o);
        end
        en_i[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (clk_o[0] !== ((i % 4) < 2) || tick_o[0] !== ((i % 4) == 3) || cfg_if.cfg_ack_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL ch0_div4_%0d: got clk %b tick %b ack %b want %b %b 0",
                         i, clk_o[0], tick_o[0], cfg_if.cfg_ack_o[0], (i % 4) < 2, (i % 4) == 3);
            end
        end
    endtask

    task automatic test_ch1_ch2();
        en_i = 3'b000;
        wr(2'd1, 16'd5, 16'd1);
        step();
        wr(2'd2, 16'd2, 16'd0);
        step();
        cfg_if.cfg_we_i = 1'b0;
        vectors++;
        if (cfg_if.cfg_pend_o !== 3'b100 || cfg_if.cfg_ack_o !== 3'b010) begin
            miscompares++;
            $display("FAIL ch12_stage: got pend %b ack %b want 100 010", cfg_if.cfg_pend_o, cfg_if.cfg_ack_o);
        end
        step();
        vectors++;
        if (cfg_if.cfg_pend_o !== 3'b000 || cfg_if.cfg_ack_o !== 3'b100) begin
            miscompares++;
            $display("FAIL ch12_apply: got pend %b ack %b want 000 100", cfg_if.cfg_pend_o, cfg_if.cfg_ack_o);
        end
        en_i = 3'b110;
        en12_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({clk_o[2], clk_o[1], tick_o[2], tick_o[1]} !== exp12(i)) begin
                miscompares++;
                $display("FAIL ch12_wave_%0d: got %b want %b", i,
                         {clk_o[2], clk_o[1], tick_o[2], tick_o[1]}, exp12(i));
            end
        end
    endtask

    task automatic test_invalid();
        logic [1:0]  sels  [3] = '{2'd0, 2'd0, 2'd3};
        logic [15:0] divs  [3] = '{16'd1, 16'd6, 16'd4};
        logic [15:0] dutys [3] = '{16'd0, 16'd6, 16'd0};
        int i;
        for (int k = 0; k < 3; k++) begin
            wr(sels[k], divs[k], dutys[k]);
            step();
            cfg_if.cfg_we_i = 1'b0;
            i = cyc - en12_cyc - 1;
            vectors++;
            if (cfg_if.cfg_err_o !== 1'b1 || cfg_if.cfg_pend_o !== 3'b000 || cfg_if.cfg_ack_o !== 3'b000
                || {clk_o[2], clk_o[1], tick_o[2], tick_o[1]} !== exp12(i)) begin
                miscompares++;
                $display("FAIL reject_%0d: got err %b pend %b ack %b wave %b want 1 000 000 %b", k,
                         cfg_if.cfg_err_o, cfg_if.cfg_pend_o, cfg_if.cfg_ack_o,
                         {clk_o[2], clk_o[1], tick_o[2], tick_o[1]}, exp12(i));
            end
            step();
            i = cyc - en12_cyc - 1;
            vectors++;
            if (cfg_if.cfg_err_o !== 1'b0 || cfg_if.cfg_pend_o !== 3'b000 || cfg_if.cfg_ack_o !== 3'b000
                || {clk_o[2], clk_o[1], tick_o[2], tick_o[1]} !== exp12(i)) begin
                miscompares++;
                $display("FAIL reject_after_%0d: got err %b pend %b ack %b wave %b want 0 000 000 %b", k,
                         cfg_if.cfg_err_o, cfg_if.cfg_pend_o, cfg_if.cfg_ack_o,
                         {clk_o[2], clk_o[1], tick_o[2], tick_o[1]}, exp12(i));
            end
        end
    endtask

    task automatic test_retime();
        logic e_clk  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic e_tick [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e_pend [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic e_ack  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        en_i = 3'b000;
        wr(2'd0, 16'd8, 16'd0);
        step();
        cfg_if.cfg_we_i = 1'b0;
        step();
        vectors++;
        if (cfg_if.cfg_ack_o !== 3'b001) begin
            miscompares++;
            $display("FAIL div8_ack: got %b want 001", cfg_if.cfg_ack_o);
        end
        en_i = 3'b001;
        step();
        step();
        wr(2'd0, 16'd3, 16'd0);
        for (int j = 0; j < 6; j++) begin
            step();
            cfg_if.cfg_we_i = 1'b0;
            vectors++;
            if (clk_o[0] !== e_clk[j] || tick_o[0] !== e_tick[j]
                || cfg_if.cfg_pend_o[0] !== e_pend[j] || cfg_if.cfg_ack_o[0] !== e_ack[j]) begin
                miscompares++;
                $display("FAIL retime_%0d: got clk %b tick %b pend %b ack %b want %b %b %b %b", j,
                         clk_o[0], tick_o[0], cfg_if.cfg_pend_o[0], cfg_if.cfg_ack_o[0],
                         e_clk[j], e_tick[j], e_pend[j], e_ack[j]);
            end
        end
        for (int j = 0; j < 6; j++) begin
            step();
            vectors++;
            if (clk_o[0] !== ((j % 3) == 0) || tick_o[0] !== ((j % 3) == 2) || cfg_if.cfg_ack_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL div3_wave_%0d: got clk %b tick %b ack %b want %b %b 0", j,
                         clk_o[0], tick_o[0], cfg_if.cfg_ack_o[0], (j % 3) == 0, (j % 3) == 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        wr(2'd0, 16'd10, 16'd0);
        step();
        wr(2'd0, 16'd6, 16'd0);
        vectors++;
        if (cfg_if.cfg_pend_o[0] !== 1'b1 || cfg_if.cfg_ack_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got pend %b ack %b want 1 0", cfg_if.cfg_pend_o[0], cfg_if.cfg_ack_o[0]);
        end
        step();
        cfg_if.cfg_we_i = 1'b0;
        vectors++;
        if (cfg_if.cfg_pend_o[0] !== 1'b1 || cfg_if.cfg_ack_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got pend %b ack %b want 1 0", cfg_if.cfg_pend_o[0], cfg_if.cfg_ack_o[0]);
        end
        step();
        vectors++;
        if (cfg_if.cfg_pend_o[0] !== 1'b0 || cfg_if.cfg_ack_o[0] !== 1'b1 || tick_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_apply: got pend %b ack %b tick %b want 0 1 1",
                     cfg_if.cfg_pend_o[0], cfg_if.cfg_ack_o[0], tick_o[0]);
        end
        for (int j = 0; j < 12; j++) begin
            step();
            vectors++;
            if (clk_o[0] !== ((j % 6) < 3) || tick_o[0] !== ((j % 6) == 5) || cfg_if.cfg_ack_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL div6_wave_%0d: got clk %b tick %b ack %b want %b %b 0", j,
                         clk_o[0], tick_o[0], cfg_if.cfg_ack_o[0], (j % 6) < 3, (j % 6) == 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        wr(2'd0, 16'd4, 16'd0);
        step();
        cfg_if.cfg_we_i = 1'b0;
        vectors++;
        if (clk_o[0] !== 1'b1 || cfg_if.cfg_pend_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got clk %b pend %b want 1 1", clk_o[0], cfg_if.cfg_pend_o[0]);
        end
        #2 reset = 1'b0;
        #1;
        got = {clk_o, tick_o, cfg_if.cfg_pend_o, cfg_if.cfg_ack_o};
        vectors++;
        if (got !== 12'h0 || cfg_if.cfg_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h err %b want 000 err 0", got, cfg_if.cfg_err_o);
        end
        en_i = 3'b001;
        step();
        step();
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            vectors++;
            if (clk_o[0] !== ((j % 10) < 5) || tick_o[0] !== ((j % 10) == 9)
                || cfg_if.cfg_pend_o[0] !== 1'b0 || cfg_if.cfg_ack_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL default_wave_%0d: got clk %b tick %b pend %b ack %b want %b %b 0 0", j,
                         clk_o[0], tick_o[0], cfg_if.cfg_pend_o[0], cfg_if.cfg_ack_o[0],
                         (j % 10) < 5, (j % 10) == 9);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ch0_basic();
        test_ch1_ch2();
        test_invalid();
        test_retime();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
